// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the equal-precision frequency meter:
// FSM state encoding, gate-select codes and the gate-length function.
package freq_meter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    MEAS  = 3'd2,
    CLOSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] GSEL_1S    = 2'd0;
  localparam logic [1:0] GSEL_100MS = 2'd1;
  localparam logic [1:0] GSEL_10MS  = 2'd2;
  localparam logic [1:0] GSEL_1MS   = 2'd3;

  // Preset gate length in reference clocks; clk_hz is a parameter, so this folds to a constant mux.
  function automatic logic [31:0] gate_ticks(input int unsigned clk_hz, input logic [1:0] sel);
    int unsigned divisor;
    case (sel)
      GSEL_1S:    divisor = 1;
      GSEL_100MS: divisor = 10;
      GSEL_10MS:  divisor = 100;
      GSEL_1MS:   divisor = 1000;
      default:    divisor = 1;
    endcase
    return 32'(clk_hz / divisor);
  endfunction

endpackage

// File: rtl/fx_sync.sv
// Synchronises the asynchronous F_in pin into the Clock domain and emits a
// one-cycle pulse per rising edge, SYNC_STAGES+1 clocks after the pin edge.
module fx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic Clock,
  input  logic CLR,
  input  logic F_in,
  output logic fx_rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   last_q, last_d;
  logic                   rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], F_in};
    last_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~last_q;
  end

  always_ff @(posedge Clock or posedge CLR) begin
    if (CLR) begin
      sync_q <= '0;
      last_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
      rise_q <= rise_d;
    end
  end

  assign fx_rise = rise_q;

endmodule

// File: rtl/equal_precision_gate.sv
// Equal-precision gate: opens and closes on F_in rising edges, counting F_in
// periods (nx) and reference clocks (ns) over the same interval.
module equal_precision_gate
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned NX_W          = 32,
  parameter int unsigned NS_W          = 32,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned TIMEOUT_GATES = 2
) (
  input  logic            Clock,
  input  logic            CLR,
  input  logic            F_in,
  input  logic            enable,
  input  logic [1:0]      gate_sel,
  output logic [NX_W-1:0] nx,
  output logic [NS_W-1:0] ns,
  output logic            result_valid,
  output logic            overflow,
  output logic            no_signal,
  output logic            gate_open
);

  state_t          state_q, state_d;
  logic [NX_W-1:0] nx_cnt_q, nx_cnt_d;
  logic [NS_W-1:0] ns_cnt_q, ns_cnt_d;
  logic            sat_q, sat_d;
  logic [31:0]     timer_q, timer_d;
  logic [31:0]     to_q, to_d;
  logic [31:0]     ticks_q, ticks_d;
  logic [NX_W-1:0] nx_q, nx_d;
  logic [NS_W-1:0] ns_q, ns_d;
  logic            ovf_q, ovf_d;
  logic            no_signal_q, no_signal_d;

  logic        fx_rise;
  logic [31:0] ticks_live, to_limit, timer_next, to_next;
  logic        timer_hit, timeout_hit;

  fx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_fx_sync (
    .Clock   (Clock),
    .CLR     (CLR),
    .F_in    (F_in),
    .fx_rise (fx_rise)
  );

  // ARM watches the live selection; CLOSE uses the gate latched at the open edge.
  assign ticks_live  = gate_ticks(CLK_HZ, gate_sel);
  assign to_limit    = (state_q == CLOSE) ? ticks_q * TIMEOUT_GATES : ticks_live * TIMEOUT_GATES;
  assign timer_next  = timer_q + 32'd1;
  assign to_next     = to_q + 32'd1;
  assign timer_hit   = (timer_next == ticks_q);
  assign timeout_hit = (to_next == to_limit);

  always_ff @(posedge Clock or posedge CLR) begin
    if (CLR) begin
      state_q     <= IDLE;
      nx_cnt_q    <= '0;
      ns_cnt_q    <= '0;
      sat_q       <= 1'b0;
      timer_q     <= '0;
      to_q        <= '0;
      ticks_q     <= '0;
      nx_q        <= '0;
      ns_q        <= '0;
      ovf_q       <= 1'b0;
      no_signal_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      nx_cnt_q    <= nx_cnt_d;
      ns_cnt_q    <= ns_cnt_d;
      sat_q       <= sat_d;
      timer_q     <= timer_d;
      to_q        <= to_d;
      ticks_q     <= ticks_d;
      nx_q        <= nx_d;
      ns_q        <= ns_d;
      ovf_q       <= ovf_d;
      no_signal_q <= no_signal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (enable) state_d = ARM;
      ARM:   if (!enable) state_d = IDLE;
             else if (fx_rise) state_d = MEAS;
      MEAS:  if (!enable) state_d = IDLE;
             else if (timer_hit) state_d = fx_rise ? DONE : CLOSE;
      CLOSE: if (!enable) state_d = IDLE;
             else if (fx_rise) state_d = DONE;
             else if (timeout_hit) state_d = ARM;
      DONE:  state_d = enable ? ARM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    nx_cnt_d    = nx_cnt_q;
    ns_cnt_d    = ns_cnt_q;
    sat_d       = sat_q;
    timer_d     = timer_q;
    to_d        = '0;
    ticks_d     = ticks_q;
    nx_d        = nx_q;
    ns_d        = ns_q;
    ovf_d       = ovf_q;
    no_signal_d = no_signal_q;
    case (state_q)
      ARM: begin
        if (fx_rise) begin
          nx_cnt_d = '0;
          ns_cnt_d = '0;
          sat_d    = 1'b0;
          timer_d  = '0;
          ticks_d  = ticks_live;
        end else if (timeout_hit) begin
          no_signal_d = 1'b1;
        end else begin
          to_d = to_next;
        end
      end
      MEAS, CLOSE: begin
        if (state_q == MEAS) timer_d = timer_next;
        else if (!fx_rise && timeout_hit) no_signal_d = 1'b1;
        else to_d = to_next;
        // Saturate rather than wrap; any lost count marks the measurement as overflowed.
        if (&ns_cnt_q) sat_d = 1'b1;
        else ns_cnt_d = ns_cnt_q + NS_W'(1);
        if (fx_rise) begin
          if (&nx_cnt_q) sat_d = 1'b1;
          else nx_cnt_d = nx_cnt_q + NX_W'(1);
        end
        if (state_d == DONE) begin
          nx_d        = nx_cnt_d;
          ns_d        = ns_cnt_d;
          ovf_d       = sat_d;
          no_signal_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    result_valid = (state_q == DONE);
    gate_open    = (state_q == MEAS) || (state_q == CLOSE);
  end

  assign nx        = nx_q;
  assign ns        = ns_q;
  assign overflow  = ovf_q;
  assign no_signal = no_signal_q;

endmodule

// File: tb/tb_equal_precision_gate.sv
// Self-checking bench: table and randomized periodic F_in measurements checked
// against a closed-form model, plus hand sequences for timeout/abort/reset.
module tb_equal_precision_gate;

  logic        clk = 1'b0;
  logic        clr;
  logic        f_in = 1'b0;
  logic        enable;
  logic [1:0]  gate_sel;
  logic [31:0] nx, ns, nx_s;
  logic [2:0]  ns_s;
  logic        rv, ovf, nosig, gopen;
  logic        rv_s, ovf_s, nosig_s, gopen_s;

  int tests = 0;
  int fails = 0;

  int fin_period = 4;
  bit fin_run = 1'b0;
  int phase = 0;

  always #5 clk = ~clk;

  equal_precision_gate #(
    .CLK_HZ(1000), .NX_W(32), .NS_W(32), .SYNC_STAGES(2), .TIMEOUT_GATES(2)
  ) dut (
    .Clock(clk), .CLR(clr), .F_in(f_in), .enable(enable), .gate_sel(gate_sel),
    .nx(nx), .ns(ns), .result_valid(rv), .overflow(ovf), .no_signal(nosig), .gate_open(gopen)
  );

  equal_precision_gate #(
    .CLK_HZ(1000), .NX_W(32), .NS_W(3), .SYNC_STAGES(2), .TIMEOUT_GATES(2)
  ) dut_sat (
    .Clock(clk), .CLR(clr), .F_in(f_in), .enable(enable), .gate_sel(gate_sel),
    .nx(nx_s), .ns(ns_s), .result_valid(rv_s), .overflow(ovf_s), .no_signal(nosig_s), .gate_open(gopen_s)
  );

  // Periodic F_in: rises once every fin_period clocks, changing mid-cycle.
  always @(posedge clk) begin
    #2;
    if (!fin_run) begin
      phase = 0;
      f_in  = 1'b0;
    end else begin
      f_in  = (phase < fin_period / 2) ? 1'b1 : 1'b0;
      phase = (phase + 1) % fin_period;
    end
  end

  typedef struct {
    int period;
    int gsel;
    int exp_nx;
    int exp_ns;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Close edge is the first F_in rise at least g clocks after the open edge.
  function automatic void model(input int p, input int g, output int enx, output int ens);
    enx = (g + p - 1) / p;
    ens = enx * p;
  endfunction

  function automatic int ticks_of(input int gsel);
    int t;
    t = 1000;
    for (int k = 0; k < gsel; k++) t = t / 10;
    return t;
  endfunction

  task automatic wait_result(input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (rv) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_gate(input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (gopen) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_result(input string name, input int enx, input int ens);
    bit got;
    int sat_ns;
    wait_result(3000, got);
    check({name, "_valid_seen"}, 64'(got), 64'd1);
    if (got) begin
      sat_ns = (ens > 7) ? 7 : ens;
      $display("[TB] %s: nx=%0d ns=%0d ovf=%0d | sat ns=%0d ovf=%0d (exp nx=%0d ns=%0d)",
               name, nx, ns, ovf, ns_s, ovf_s, enx, ens);
      check({name, "_nx"}, 64'(nx), 64'(enx));
      check({name, "_ns"}, 64'(ns), 64'(ens));
      check({name, "_ovf"}, 64'(ovf), 64'd0);
      check({name, "_nosig"}, 64'(nosig), 64'd0);
      check({name, "_sat_nx"}, 64'(nx_s), 64'(enx));
      check({name, "_sat_ns"}, 64'(ns_s), 64'(sat_ns));
      check({name, "_sat_ovf"}, 64'(ovf_s), (ens > 7) ? 64'd1 : 64'd0);
      @(negedge clk);
      check({name, "_rv_single"}, 64'(rv), 64'd0);
    end
  endtask

  task automatic start_run(input int p, input int gsel);
    enable  = 1'b0;
    fin_run = 1'b0;
    repeat (6) @(negedge clk);
    gate_sel   = 2'(gsel);
    fin_period = p;
    fin_run    = 1'b1;
    enable     = 1'b1;
  endtask

  initial begin
    bit got;
    bit rv_seen;
    int p, gsel, enx, ens;

    vecs[0] = '{4, 2, 3, 12};
    vecs[1] = '{5, 2, 2, 10};
    vecs[2] = '{3, 2, 4, 12};
    vecs[3] = '{7, 2, 2, 14};
    vecs[4] = '{2, 3, 1, 2};
    vecs[5] = '{10, 2, 1, 10};
    vecs[6] = '{6, 2, 2, 12};

    clr      = 1'b1;
    enable   = 1'b0;
    gate_sel = 2'd2;
    repeat (2) @(negedge clk);
    check("rst_nx", 64'(nx), 64'd0);
    check("rst_ns", 64'(ns), 64'd0);
    check("rst_rv", 64'(rv), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_nosig", 64'(nosig), 64'd0);
    check("rst_gate", 64'(gopen), 64'd0);
    clr = 1'b0;

    // No signal: 20-clock ARM timeout with F_in held low.
    repeat (3) @(negedge clk);
    enable  = 1'b1;
    rv_seen = 1'b0;
    repeat (18) begin
      @(negedge clk);
      if (rv) rv_seen = 1'b1;
    end
    check("nosig_early", 64'(nosig), 64'd0);
    repeat (4) begin
      @(negedge clk);
      if (rv) rv_seen = 1'b1;
    end
    check("nosig_set", 64'(nosig), 64'd1);
    check("nosig_no_rv", 64'(rv_seen), 64'd0);
    $display("[TB] no_signal sequence: no_signal=%0d rv_seen=%0d", nosig, rv_seen);
    fin_period = 4;
    fin_run    = 1'b1;
    check_result("nosig_recover", 3, 12);

    foreach (vecs[i]) begin
      start_run(vecs[i].period, vecs[i].gsel);
      check_result($sformatf("vec%0d_first", i), vecs[i].exp_nx, vecs[i].exp_ns);
      check_result($sformatf("vec%0d_repeat", i), vecs[i].exp_nx, vecs[i].exp_ns);
    end

    for (int t = 0; t < 10; t++) begin
      case ($urandom_range(0, 3))
        0:       begin gsel = 3; p = $urandom_range(2, 3);  end
        1:       begin gsel = 1; p = $urandom_range(2, 15); end
        default: begin gsel = 2; p = $urandom_range(2, 15); end
      endcase
      model(p, ticks_of(gsel), enx, ens);
      start_run(p, gsel);
      check_result($sformatf("rnd%0d_p%0d_g%0d_a", t, p, gsel), enx, ens);
      check_result($sformatf("rnd%0d_p%0d_g%0d_b", t, p, gsel), enx, ens);
    end

    // gate_sel change during MEAS only affects the next measurement.
    start_run(4, 2);
    wait_gate(200, got);
    check("gsel_gate_open", 64'(got), 64'd1);
    gate_sel = 2'd0;
    check_result("gsel_keep", 3, 12);
    check_result("gsel_new", 250, 1000);

    // enable dropped mid-measurement.
    start_run(4, 2);
    check_result("en_pre", 3, 12);
    wait_gate(200, got);
    check("en_gate_open", 64'(got), 64'd1);
    enable = 1'b0;
    @(negedge clk);
    check("en_drop_gate", 64'(gopen), 64'd0);
    check("en_drop_nx", 64'(nx), 64'd3);
    check("en_drop_ns", 64'(ns), 64'd12);
    rv_seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (rv) rv_seen = 1'b1;
    end
    check("en_drop_no_rv", 64'(rv_seen), 64'd0);
    $display("[TB] enable drop: gate_open=%0d nx=%0d ns=%0d rv_seen=%0d", gopen, nx, ns, rv_seen);

    // CLR mid-measurement clears outputs at once.
    enable = 1'b1;
    wait_gate(200, got);
    check("clr_gate_open", 64'(got), 64'd1);
    clr = 1'b1;
    #1;
    check("clr_nx", 64'(nx), 64'd0);
    check("clr_ns", 64'(ns), 64'd0);
    check("clr_gate", 64'(gopen), 64'd0);
    check("clr_rv", 64'(rv), 64'd0);
    check("clr_ovf", 64'(ovf), 64'd0);
    check("clr_nosig", 64'(nosig), 64'd0);
    $display("[TB] clr mid-meas: nx=%0d ns=%0d gate_open=%0d", nx, ns, gopen);
    @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
